// File: rtl/lcd_text_buffer_if.sv
// rtl/lcd_text_buffer_if.sv - access bus between the LCD driver/host and the text buffer
interface lcd_text_buffer_if;
  logic [7:0] addr;
  logic       rd;
  logic [7:0] data;
  logic       wr_req;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wr_ack;
  logic       scroll_req;
  logic       clear_req;
  logic       busy;

  modport master (
    output addr, rd, wr_req, wr_addr, wr_data, scroll_req, clear_req,
    input  data, wr_ack, busy
  );

  modport slave (
    input  addr, rd, wr_req, wr_addr, wr_data, scroll_req, clear_req,
    output data, wr_ack, busy
  );
endinterface

// File: rtl/lcd_text_buffer.sv
// rtl/lcd_text_buffer.sv - two-line SC1602 frame store with read/sequencer/host arbitration
// Driver reads always win; the scroll/clear sequencer freezes on any read cycle.
module lcd_text_buffer #(
  parameter logic [7:0] FILL_CHAR = 8'h20,
  parameter int         COLS      = 16
) (
  input  logic             clk,
  input  logic             resetn,
  lcd_text_buffer_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_CLR, S_SCR_RD, S_SCR_WR1, S_SCR_WR2} state_t;

  state_t     r_state, w_next;
  logic [7:0] r_mem [0:2*COLS-1];
  logic [4:0] r_cnt;
  logic [7:0] r_tmp;
  logic [7:0] r_data;
  logic       r_wr_ack;

  logic       w_rd_valid, w_wr_valid, w_host_commit;
  logic [4:0] w_rd_idx, w_wr_idx;
  logic       w_busy, w_we, w_tmp_ld;
  logic [4:0] w_widx, w_cnt_next;
  logic [7:0] w_wdata;

  // DDRAM line 1 lives at 0x00-0x0F, line 2 at 0x40-0x4F; bit 6 picks the line
  assign w_rd_valid = (bus.addr[7:4] == 4'h0) || (bus.addr[7:4] == 4'h4);
  assign w_rd_idx   = {bus.addr[6], bus.addr[3:0]};
  assign w_wr_valid = (bus.wr_addr[7:4] == 4'h0) || (bus.wr_addr[7:4] == 4'h4);
  assign w_wr_idx   = {bus.wr_addr[6], bus.wr_addr[3:0]};

  assign w_host_commit = (r_state == S_IDLE) && bus.wr_req && !bus.rd && !r_wr_ack &&
                         !bus.clear_req && !bus.scroll_req;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (!bus.rd) begin
      case (r_state)
        S_IDLE: begin
          if (bus.clear_req)       w_next = S_CLR;
          else if (bus.scroll_req) w_next = S_SCR_RD;
        end
        S_CLR:     if (r_cnt == 5'(2*COLS-1)) w_next = S_IDLE;
        S_SCR_RD:  w_next = S_SCR_WR1;
        S_SCR_WR1: w_next = S_SCR_WR2;
        S_SCR_WR2: w_next = (r_cnt == 5'(COLS-1)) ? S_IDLE : S_SCR_RD;
        default:   w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_busy     = (r_state != S_IDLE);
    w_we       = 1'b0;
    w_widx     = w_wr_idx;
    w_wdata    = bus.wr_data;
    w_tmp_ld   = 1'b0;
    w_cnt_next = r_cnt;
    if (!bus.rd) begin
      case (r_state)
        S_IDLE: begin
          w_we = w_host_commit && w_wr_valid;
          if (bus.clear_req || bus.scroll_req) w_cnt_next = 5'd0;
        end
        S_CLR: begin
          w_we    = 1'b1;
          w_widx  = r_cnt;
          w_wdata = FILL_CHAR;
          if (r_cnt != 5'(2*COLS-1)) w_cnt_next = r_cnt + 5'd1;
        end
        S_SCR_RD: w_tmp_ld = 1'b1;
        S_SCR_WR1: begin
          w_we    = 1'b1;
          w_widx  = {1'b0, r_cnt[3:0]};
          w_wdata = r_tmp;
        end
        S_SCR_WR2: begin
          w_we    = 1'b1;
          w_widx  = {1'b1, r_cnt[3:0]};
          w_wdata = FILL_CHAR;
          if (r_cnt != 5'(COLS-1)) w_cnt_next = r_cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 2*COLS; i++) r_mem[i] <= FILL_CHAR;
      r_data   <= 8'h00;
      r_tmp    <= 8'h00;
      r_wr_ack <= 1'b0;
      r_cnt    <= 5'd0;
    end else begin
      if (w_we)     r_mem[w_widx] <= w_wdata;
      if (bus.rd)   r_data <= w_rd_valid ? r_mem[w_rd_idx] : FILL_CHAR;
      if (w_tmp_ld) r_tmp <= r_mem[{1'b1, r_cnt[3:0]}];
      r_wr_ack <= w_host_commit;
      r_cnt    <= w_cnt_next;
    end
  end

  assign bus.data   = r_data;
  assign bus.wr_ack = r_wr_ack;
  assign bus.busy   = w_busy;

endmodule

// File: doc/lcd_text_buffer.md
Name: lcd_text_buffer

Overview:
- Character frame store and access arbiter feeding the SC1602 4-bit LCD driver.
- Holds two 16-character lines, one byte per character, mapped at the LCD DDRAM addresses: line 1 at 0x00-0x0F, line 2 at 0x40-0x4F.
- Shares a single-port storage model between three requesters: the driver refresh read port, the host write port, and an internal scroll/clear sequencer.
- The driver read port always wins, so the LCD refresh loop never stalls.

Parameters:
- FILL_CHAR, 8'h20, byte written by clear, scroll and reset (ASCII space).
- COLS, 16, characters per line; fixed at 16 for the SC1602.

Ports:
- clk  input  1  system clock
- resetn  input  1  asynchronous active-low reset
- addr  input  8  driver read address (DDRAM-style)
- rd  input  1  driver read strobe, one-cycle pulse
- data  output  8  read data, valid the cycle after rd
- wr_req  input  1  host write request, held until wr_ack
- wr_addr  input  8  host write address (DDRAM-style)
- wr_data  input  8  host write byte
- wr_ack  output  1  one-cycle pulse, write committed
- scroll_req  input  1  copy line 2 to line 1, then fill line 2 with FILL_CHAR
- clear_req  input  1  fill both lines with FILL_CHAR
- busy  output  1  high while a scroll or clear is in progress

Behaviour:
- Reset (async, resetn=0):
  - All 32 entries = FILL_CHAR; data = 8'h00; wr_ack = 0; busy = 0; state = IDLE; column counter = 0.
  - Reset mid-scroll or mid-clear aborts immediately; the buffer is re-initialised.
- Address decode:
  - Valid addresses are 0x00-0x0F (index = addr[3:0]) and 0x40-0x4F (index = 16 + addr[3:0]).
  - Any other address is invalid. Invalid reads return FILL_CHAR. Invalid writes are acked but not stored.
- Storage is single-ported: at most one access (read or write) per cycle.
  - Priority: driver rd > sequencer > host write.
- Driver read:
  - When rd=1 is sampled, data is registered on the next edge, giving 1-cycle latency.
  - data holds its value when rd=0.
  - rd is never stalled or refused.
- Host write:
  - Commits in a cycle where state=IDLE, wr_req=1, rd=0, wr_ack=0, and neither clear_req nor scroll_req is asserted.
  - wr_ack=1 in the following cycle.
  - wr_req is ignored while wr_ack=1, so a held request cannot double-write; back-to-back writes are therefore at most one per 2 cycles.
  - A request arriving while busy=1 is held pending; no ack is issued until the operation completes.
- Sequencer FSM states: IDLE, CLR, SCR_RD, SCR_WR1, SCR_WR2.
  - IDLE: if clear_req, go to CLR with counter=0 and busy=1. Else if scroll_req, go to SCR_RD with counter=0 and busy=1. Clear wins when both are asserted.
  - CLR: write FILL_CHAR to entry counter, then increment. After entry 31, go to IDLE and set busy=0. 32 accesses.
  - SCR_RD: read entry 16+counter into a temp register.
  - SCR_WR1: write temp to entry counter.
  - SCR_WR2: write FILL_CHAR to entry 16+counter. If counter=15, go to IDLE and set busy=0; else increment counter and go to SCR_RD.
  - Scroll takes 48 accesses.
- Stall rule: any cycle with rd=1 freezes the sequencer (no state or counter change) and blocks host writes.
  - Unstalled clear = 32 cycles; unstalled scroll = 48 cycles.
- Request sampling:
  - scroll_req and clear_req are sampled only in IDLE; requests while busy are ignored.
  - Requests are level-sensitive: a level held after completion restarts the operation.
- Driver reads during scroll/clear return the current, partially updated contents. Tearing is accepted.
- Counter is 5 bits; no wrap beyond 31 (CLR) or 15 (scroll).

Test Plan:
- Reset, then rd addr=0x00, then 0x4F, then 0x20 -> data=8'h20 one cycle after each rd; busy=0; wr_ack=0.
- Host write 0x41 to 0x05 and 0x5A to 0x4A, holding wr_req -> one wr_ack per write, each the cycle after commit; reads of 0x05/0x4A return 0x41/0x5A; no double write while wr_req is held through the ack cycle.
- Load line 2 with 0x30+col (col 0..15), pulse scroll_req -> busy high exactly 48 cycles; then line 1 = 0x30..0x3F and line 2 = all 8'h20.
- Start clear, inject rd every 3rd cycle -> busy duration = 32 + number of rd cycles; every rd returns data next cycle; all entries = 8'h20 at the end.
- Assert clear_req and scroll_req together, and wr_req during busy -> clear executes and scroll is ignored; wr_ack only after busy falls.
- Deassert resetn at scroll counter=7 -> busy=0 and all entries = 8'h20 immediately after reset.
